eth_loopback_fifo: RTL and testbench
====================================

ETH_LOOPBACK_FIFO -- requirements
Module: eth_loopback_fifo

Interface
REQ-001 Parameter DATA_W, default 256, stream data width in bits.
REQ-002 Parameter ADDR_W, default 4, stream address width in bits.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of 2, >= 4.
REQ-004 Parameter MODE, default LB_CUT_THROUGH, forwarding mode (LB_CUT_THROUGH or LB_STORE_FWD).
REQ-005 Parameter LED_LSB, default 24, LSB of the data byte mirrored to the LEDs.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 rx_valid/rx_ready  in/out  1/1  inbound handshake.
REQ-009 rx_data/rx_addr  in  DATA_W/ADDR_W  inbound word and address.
REQ-010 rx_sop/rx_eop  in  1/1  inbound start/end of packet.
REQ-011 tx_valid/tx_ready  out/in  1/1  outbound handshake.
REQ-012 tx_data/tx_addr  out  DATA_W/ADDR_W  outbound word and address.
REQ-013 tx_sop/tx_eop  out  1/1  outbound start/end of packet.
REQ-014 leds  out  8  active-low LED drive.
REQ-015 pkt_count  out  32  packets returned (tx eop handshakes).
REQ-016 sop_err  out  1  sticky: rx_sop accepted inside an open packet.

Function
REQ-017 A transfer occurs on a port in any cycle where valid and ready are both high.
REQ-018 Each accepted rx word (data, addr, sop, eop) is written to a DEPTH-entry FIFO and returned on tx unmodified, in order, with no loss or duplication.
REQ-019 rx_ready = (count < DEPTH) while not in reset; depends on registered state only.
REQ-020 Push and pop in the same cycle leave count unchanged; push alone +1; pop alone -1.
REQ-021 When full, rx_ready is low; a pop in that cycle raises rx_ready the next cycle.
REQ-022 LB_CUT_THROUGH: tx_valid = (count != 0); minimum latency rx handshake at edge N -> tx_valid at cycle N+1.
REQ-023 LB_STORE_FWD: tx_valid = (count != 0) and (pkts_held != 0), where pkts_held counts buffered eop words (+1 on rx eop push, -1 on tx eop pop, both -> unchanged).
REQ-024 LB_STORE_FWD overflow release: when count == DEPTH and pkts_held == 0, tx_valid is asserted until that packet's eop is popped.
REQ-025 tx outputs hold stable while tx_valid high and tx_ready low.
REQ-026 tx_valid may assert regardless of tx_ready; tx_ready may stay low indefinitely without data loss.
REQ-027 led_bits register loads rx_data[LED_LSB+7:LED_LSB] on every rx handshake; leds = ~led_bits.
REQ-028 pkt_count increments on each tx handshake with tx_eop high; wraps 2^32-1 -> 0.
REQ-029 An rx-side in_pkt flag sets on accepted sop without eop, clears on accepted eop; sop with eop is a one-word packet.
REQ-030 sop_err sets when rx_sop is accepted while in_pkt = 1; word is still forwarded; cleared only by reset.

Reset
REQ-031 While resetn = 0: rx_ready = 0, tx_valid = 0, count = 0, pkts_held = 0, pointers = 0, in_pkt = 0, led_bits = 0 (leds = 8'hFF), pkt_count = 0, sop_err = 0.
REQ-032 Reset mid-packet discards all FIFO contents; first cycle after release rx_ready = 1, tx_valid = 0.
REQ-033 FIFO storage array is not reset.

Structure
REQ-034 Package eth_loopback_pkg holds the MODE enum (LB_CUT_THROUGH = 0, LB_STORE_FWD = 1) and LED_W = 8.
REQ-035 Storage, pointers and count live in sub-module eth_lb_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); the top owns mode gating, counters and LEDs.

Verification
REQ-036 Cut-through, tx_ready = 1, 8-word packet data 0x01000000..0x08000000 -> returned identical, 1-cycle latency, pkt_count = 1, leds = ~8'h08.
REQ-037 tx_ready = 0, push 20 words (DEPTH 16) -> rx_ready low after 16th; raise tx_ready -> all 20 returned in order.
REQ-038 Store-fwd, 3-word packet with 2-cycle gaps -> tx_valid stays low until cycle after eop push, then 3 back-to-back words.
REQ-039 Store-fwd, 20-word packet, DEPTH 16 -> overflow release at full; all 20 words returned, no deadlock, pkt_count = 1.
REQ-040 sop, data, sop -> sop_err = 1 after second sop, both packets still returned; reset mid-stream -> all outputs at REQ-031 values.
REQ-041 Random valid/ready, 1000 packets of 1..40 words, both modes -> scoreboard match, pkt_count = 1000.

Source files
------------

// File: rtl/eth_loopback_pkg.sv
// Shared types and constants for the Ethernet loopback FIFO.
package eth_loopback_pkg;

  // Forwarding policy: stream words as soon as buffered, or hold whole packets.
  typedef enum logic {
    LB_CUT_THROUGH = 1'b0,
    LB_STORE_FWD   = 1'b1
  } lb_mode_e;

  // Number of LEDs mirrored from the inbound data stream.
  localparam int LED_W = 8;

endpackage

// File: rtl/eth_lb_fifo.sv
// Synchronous FIFO with first-word fall-through read: the head entry is
// visible on rdata whenever the FIFO is not empty.
module eth_lb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Guard against overrun/underrun even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head entry is read combinationally so tx sees it the cycle after a push.
  assign rdata = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/eth_loopback_fifo.sv
// Loopback of a packet stream through a FIFO, with cut-through or
// store-and-forward release, LED mirror, packet counter and framing check.
module eth_loopback_fifo
  import eth_loopback_pkg::*;
#(
  parameter int       DATA_W  = 256,
  parameter int       ADDR_W  = 4,
  parameter int       DEPTH   = 16,
  parameter lb_mode_e MODE    = LB_CUT_THROUGH,
  parameter int       LED_LSB = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic              rx_sop,
  input  logic              rx_eop,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] tx_addr,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [LED_W-1:0]  leds,
  output logic [31:0]       pkt_count,
  output logic              sop_err
);

  localparam int WORD_W = DATA_W + ADDR_W + 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              push_eop;
  logic              pop_eop;

  logic [CNT_W-1:0]  pkts_held_reg;
  logic              release_reg;
  logic              held_empty;
  logic              release_now;
  logic              tx_gate;
  logic              in_pkt_reg;
  logic              sop_err_reg;
  logic [LED_W-1:0]  led_bits_reg;
  logic [31:0]       pkt_count_reg;

  assign wr_word = {rx_sop, rx_eop, rx_addr, rx_data};
  assign {tx_sop, tx_eop, tx_addr, tx_data} = rd_word;

  eth_lb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_word),
    .rdata  (rd_word),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Both handshakes are qualified by reset so nothing moves while resetn is low.
  assign rx_ready = resetn && (fifo_count < CNT_W'(DEPTH));
  assign push     = rx_valid && rx_ready;
  assign pop      = tx_valid && tx_ready;
  assign push_eop = push && rx_eop;
  assign pop_eop  = pop && tx_eop;

  // A full FIFO with no complete packet inside can never gain one, so the
  // partial packet is released to avoid deadlock.
  assign held_empty  = (pkts_held_reg == '0);
  assign release_now = fifo_full && held_empty;

  // Store-and-forward only offers data once a whole packet (or overflow) is held.
  always_comb begin
    tx_gate = 1'b1;
    if (MODE == LB_STORE_FWD) begin
      tx_gate = !held_empty || release_reg || release_now;
    end
  end

  assign tx_valid = resetn && !fifo_empty && tx_gate;

  // Count buffered end-of-packet words and track an in-progress overflow release.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkts_held_reg <= '0;
      release_reg   <= 1'b0;
    end else begin
      case ({push_eop, pop_eop})
        2'b10:   pkts_held_reg <= pkts_held_reg + CNT_W'(1);
        2'b01:   pkts_held_reg <= pkts_held_reg - CNT_W'(1);
        default: pkts_held_reg <= pkts_held_reg;
      endcase
      if (pop_eop) begin
        release_reg <= 1'b0;
      end else if (release_now) begin
        release_reg <= 1'b1;
      end
    end
  end

  // Inbound framing: open-packet flag and sticky duplicate-sop error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_pkt_reg  <= 1'b0;
      sop_err_reg <= 1'b0;
    end else if (push) begin
      if (rx_sop && in_pkt_reg) begin
        sop_err_reg <= 1'b1;
      end
      if (rx_eop) begin
        in_pkt_reg <= 1'b0;
      end else if (rx_sop) begin
        in_pkt_reg <= 1'b1;
      end
    end
  end

  // Mirror one byte of each accepted word to the LEDs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_bits_reg <= '0;
    end else if (push) begin
      led_bits_reg <= rx_data[LED_LSB +: LED_W];
    end
  end

  // Count packets leaving on tx; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count_reg <= '0;
    end else if (pop_eop) begin
      pkt_count_reg <= pkt_count_reg + 32'd1;
    end
  end

  assign leds      = ~led_bits_reg;
  assign pkt_count = pkt_count_reg;
  assign sop_err   = sop_err_reg;

endmodule

// File: tb/tb_eth_loopback_fifo.sv
// Directed and randomized checks of eth_loopback_fifo in both forwarding modes.
// Lane 0 is a cut-through instance, lane 1 a store-and-forward instance.
module tb_eth_loopback_fifo;
  import eth_loopback_pkg::*;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int WORD_W = DATA_W + ADDR_W + 2;

  typedef logic [WORD_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rx_valid  [2];
  logic              rx_ready  [2];
  logic [DATA_W-1:0] rx_data   [2];
  logic [ADDR_W-1:0] rx_addr   [2];
  logic              rx_sop    [2];
  logic              rx_eop    [2];
  logic              tx_valid  [2];
  logic              tx_ready  [2];
  logic [DATA_W-1:0] tx_data   [2];
  logic [ADDR_W-1:0] tx_addr   [2];
  logic              tx_sop    [2];
  logic              tx_eop    [2];
  logic [7:0]        leds      [2];
  logic [31:0]       pkt_count [2];
  logic              sop_err   [2];
  logic              done      [2];

  int    total = 0;
  int    bad   = 0;
  word_t exp_q0 [$];
  word_t exp_q1 [$];

  always #5 clk = ~clk;

  eth_loopback_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MODE(LB_CUT_THROUGH), .LED_LSB(24)
  ) dut_ct (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]), .rx_addr(rx_addr[0]),
    .rx_sop(rx_sop[0]), .rx_eop(rx_eop[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_addr(tx_addr[0]),
    .tx_sop(tx_sop[0]), .tx_eop(tx_eop[0]),
    .leds(leds[0]), .pkt_count(pkt_count[0]), .sop_err(sop_err[0])
  );

  eth_loopback_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MODE(LB_STORE_FWD), .LED_LSB(24)
  ) dut_sf (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]), .rx_addr(rx_addr[1]),
    .rx_sop(rx_sop[1]), .rx_eop(rx_eop[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_addr(tx_addr[1]),
    .tx_sop(tx_sop[1]), .tx_eop(tx_eop[1]),
    .leds(leds[1]), .pkt_count(pkt_count[1]), .sop_err(sop_err[1])
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard pop: compare one returned word with the oldest accepted one.
  task automatic sb_pop(input int m, input word_t got);
    word_t e;
    int    n;
    n = (m == 0) ? exp_q0.size() : exp_q1.size();
    total++;
    assert (n != 0) else begin
      bad++;
      $error("FAIL sb_extra lane=%0d observed=%0h expected=none", m, got);
    end
    if (n != 0) begin
      if (m == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      total++;
      assert (got === e) else begin
        bad++;
        $error("FAIL sb_word lane=%0d observed=%0h expected=%0h", m, got, e);
      end
    end
  endtask

  // Record rx handshakes and check tx handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (rx_valid[0] && rx_ready[0]) exp_q0.push_back({rx_sop[0], rx_eop[0], rx_addr[0], rx_data[0]});
      if (rx_valid[1] && rx_ready[1]) exp_q1.push_back({rx_sop[1], rx_eop[1], rx_addr[1], rx_data[1]});
      if (tx_valid[0] && tx_ready[0]) sb_pop(0, {tx_sop[0], tx_eop[0], tx_addr[0], tx_data[0]});
      if (tx_valid[1] && tx_ready[1]) sb_pop(1, {tx_sop[1], tx_eop[1], tx_addr[1], tx_data[1]});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word; returns just after the edge on which it was accepted.
  task automatic send_word(input int m, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                           input logic s, input logic e);
    int t;
    rx_valid[m] = 1'b1; rx_data[m] = d; rx_addr[m] = a; rx_sop[m] = s; rx_eop[m] = e;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rx_ready[m]) break;
    end
    total++;
    assert (t < 300) else begin
      bad++;
      $error("FAIL rx_timeout lane=%0d observed=ready_low expected=ready_high", m);
    end
    @(posedge clk);
    #1;
    rx_valid[m] = 1'b0; rx_sop[m] = 1'b0; rx_eop[m] = 1'b0;
  endtask

  // Wait until everything accepted on a lane has come back out.
  task automatic drain(input int m);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (((m == 0) ? exp_q0.size() : exp_q1.size()) == 0 && !tx_valid[m]) break;
    end
    total++;
    assert (t < 300) else begin
      bad++;
      $error("FAIL drain_timeout lane=%0d observed=words_left expected=empty", m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lane(input int m);
    int                len;
    logic [DATA_W-1:0] d;
    for (int p = 0; p < 1000; p++) begin
      len = int'($urandom_range(1, 40));
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 3) == 0) cyc(1);
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
        send_word(m, d, ADDR_W'($urandom), w == 0, w == len - 1);
      end
    end
    done[m] = 1'b1;
  endtask

  task automatic rand_ready(input int m);
    while (!done[m]) begin
      tx_ready[m] = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    tx_ready[m] = 1'b1;
  endtask

  task automatic chk_reset_state(input int m);
    chk_bit("rst_rx_ready", rx_ready[m], 1'b0);
    chk_bit("rst_tx_valid", tx_valid[m], 1'b0);
    chk_val("rst_leds", DATA_W'(leds[m]), DATA_W'(8'hFF));
    chk_val("rst_pkt_count", DATA_W'(pkt_count[m]), DATA_W'(0));
    chk_bit("rst_sop_err", sop_err[m], 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rx_valid[m] = 1'b0; rx_data[m] = '0; rx_addr[m] = '0; rx_sop[m] = 1'b0; rx_eop[m] = 1'b0;
      tx_ready[m] = 1'b0; done[m] = 1'b0;
    end

    // Reset values, then release.
    cyc(2);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk_reset_state(m);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk_bit("rel_rx_ready", rx_ready[m], 1'b1);
      chk_bit("rel_tx_valid", tx_valid[m], 1'b0);
    end
    @(posedge clk); #1;

    // Cut-through 8-word packet, each word visible on tx one cycle after acceptance.
    tx_ready[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send_word(0, DATA_W'(i) << 24, ADDR_W'(i), i == 1, i == 8);
      @(negedge clk);
      chk_bit("ct_latency_valid", tx_valid[0], 1'b1);
      chk_val("ct_data", tx_data[0], DATA_W'(i) << 24);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_bit("ct_idle_valid", tx_valid[0], 1'b0);
    chk_val("ct_pkt_count", DATA_W'(pkt_count[0]), DATA_W'(1));
    chk_val("ct_leds", DATA_W'(leds[0]), DATA_W'(8'hF7));
    @(posedge clk); #1;

    // Fill to DEPTH with tx stalled, then release backpressure.
    tx_ready[0] = 1'b0;
    for (int i = 0; i < 16; i++) send_word(0, DATA_W'(32'hA000 + i), ADDR_W'(i), i == 0, 1'b0);
    @(negedge clk);
    chk_bit("full_rx_ready", rx_ready[0], 1'b0);
    chk_bit("full_tx_valid", tx_valid[0], 1'b1);
    chk_val("full_head", tx_data[0], DATA_W'(32'hA000));
    @(posedge clk); #1;
    rx_valid[0] = 1'b1; rx_data[0] = DATA_W'(32'hA010); rx_addr[0] = ADDR_W'(0);
    cyc(2);
    @(negedge clk);
    chk_bit("stall_rx_ready", rx_ready[0], 1'b0);
    chk_val("stall_head_stable", tx_data[0], DATA_W'(32'hA000));
    @(posedge clk); #1;
    tx_ready[0] = 1'b1;
    @(negedge clk);
    chk_bit("pop_cycle_rx_ready", rx_ready[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("after_pop_rx_ready", rx_ready[0], 1'b1);
    @(posedge clk); #1;
    rx_valid[0] = 1'b0;
    for (int i = 17; i < 20; i++) send_word(0, DATA_W'(32'hA000 + i), ADDR_W'(i), 1'b0, i == 19);
    drain(0);
    chk_val("bp_pkt_count", DATA_W'(pkt_count[0]), DATA_W'(2));

    // Store-and-forward 3-word packet with gaps: nothing leaves until eop is in.
    tx_ready[1] = 1'b1;
    send_word(1, DATA_W'(32'h11000000), ADDR_W'(1), 1'b1, 1'b0);
    repeat (2) begin @(negedge clk); chk_bit("sf_hold_a", tx_valid[1], 1'b0); @(posedge clk); #1; end
    send_word(1, DATA_W'(32'h22000000), ADDR_W'(2), 1'b0, 1'b0);
    repeat (2) begin @(negedge clk); chk_bit("sf_hold_b", tx_valid[1], 1'b0); @(posedge clk); #1; end
    send_word(1, DATA_W'(32'h33000000), ADDR_W'(3), 1'b0, 1'b1);
    @(negedge clk);
    chk_bit("sf_valid_a", tx_valid[1], 1'b1);
    chk_val("sf_data_a", tx_data[1], DATA_W'(32'h11000000));
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("sf_valid_b", tx_valid[1], 1'b1);
    chk_val("sf_data_b", tx_data[1], DATA_W'(32'h22000000));
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("sf_valid_c", tx_valid[1], 1'b1);
    chk_val("sf_data_c", tx_data[1], DATA_W'(32'h33000000));
    chk_bit("sf_eop_c", tx_eop[1], 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_bit("sf_done_valid", tx_valid[1], 1'b0);
    chk_val("sf_pkt_count", DATA_W'(pkt_count[1]), DATA_W'(1));
    @(posedge clk); #1;

    // Store-and-forward 20-word packet: overflow release at full.
    for (int i = 0; i < 20; i++) begin
      send_word(1, DATA_W'(32'hB000 + i), ADDR_W'(i), i == 0, i == 19);
      if (i == 14) begin
        @(negedge clk);
        chk_bit("sf_no_early_release", tx_valid[1], 1'b0);
        @(posedge clk); #1;
      end
    end
    drain(1);
    chk_val("ovf_pkt_count", DATA_W'(pkt_count[1]), DATA_W'(2));
    send_word(1, DATA_W'(32'hC000), ADDR_W'(5), 1'b1, 1'b0);
    @(negedge clk);
    chk_bit("release_cleared", tx_valid[1], 1'b0);
    @(posedge clk); #1;
    send_word(1, DATA_W'(32'hC001), ADDR_W'(6), 1'b0, 1'b1);
    drain(1);
    chk_val("post_ovf_pkt_count", DATA_W'(pkt_count[1]), DATA_W'(3));

    // Duplicate sop: flagged but forwarded.
    send_word(0, DATA_W'(32'hD000), ADDR_W'(1), 1'b1, 1'b0);
    @(negedge clk); chk_bit("sop_err_clean", sop_err[0], 1'b0); @(posedge clk); #1;
    send_word(0, DATA_W'(32'hD001), ADDR_W'(2), 1'b0, 1'b0);
    send_word(0, DATA_W'(32'hD002), ADDR_W'(3), 1'b1, 1'b0);
    @(negedge clk); chk_bit("sop_err_set", sop_err[0], 1'b1); @(posedge clk); #1;
    send_word(0, DATA_W'(32'hD003), ADDR_W'(4), 1'b0, 1'b1);
    drain(0);
    chk_bit("sop_err_sticky", sop_err[0], 1'b1);
    chk_val("sop_pkt_count", DATA_W'(pkt_count[0]), DATA_W'(3));

    // Reset in the middle of a stalled packet.
    tx_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) send_word(0, DATA_W'(32'hE000 + i), ADDR_W'(i), i == 0, 1'b0);
    rx_valid[0] = 1'b1; rx_data[0] = DATA_W'(32'hE003);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk_reset_state(m);
    @(posedge clk); #1;
    resetn = 1'b1; rx_valid[0] = 1'b0;
    @(negedge clk);
    chk_bit("mid_rel_rx_ready", rx_ready[0], 1'b1);
    chk_bit("mid_rel_tx_valid", tx_valid[0], 1'b0);
    @(posedge clk); #1;
    tx_ready[0] = 1'b1;
    @(negedge clk);
    chk_bit("mid_discarded", tx_valid[0], 1'b0);
    @(posedge clk); #1;
    send_word(0, DATA_W'(32'hF000), ADDR_W'(0), 1'b1, 1'b1);
    @(negedge clk); chk_bit("in_pkt_was_reset", sop_err[0], 1'b0); @(posedge clk); #1;
    drain(0);

    // Randomized traffic on both lanes concurrently.
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    fork
      rand_lane(0);
      rand_lane(1);
      rand_ready(0);
      rand_ready(1);
    join
    drain(0);
    drain(1);
    chk_val("rand_ct_pkt_count", DATA_W'(pkt_count[0]), DATA_W'(1000));
    chk_val("rand_sf_pkt_count", DATA_W'(pkt_count[1]), DATA_W'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
